// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the toy RV32I core: fetches into IR, decodes the opcode into
// datapath selects and walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB.

package riscv_pkg;
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;
endpackage

module multicycle_control
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_IR        = 32'h0000_0013,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_i,
  input  logic        branch_taken_i,
  output logic [31:0] instr_o,
  output imm_type_e   imm_type_o,
  output logic        alu_src_a_o,
  output logic        alu_src_b_o,
  output logic        alu_out_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        illegal_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StTrap    = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    KOp, KOpImm, KLoad, KStore, KBranch, KLui, KAuipc, KJal, KJalr, KMisc, KIllegal
  } kind_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic        illegal_q;
  kind_e       kind, eff_kind;
  imm_type_e   imm_type;
  logic        is_illegal;

  always_comb begin
    kind     = KIllegal;
    imm_type = IMM_NONE;
    if (ir_q[1:0] == 2'b11) begin
      case (ir_q[6:0])
        7'b0110011: kind = KOp;
        7'b0010011: begin kind = KOpImm;  imm_type = IMM_I; end
        7'b0000011: begin kind = KLoad;   imm_type = IMM_I; end
        7'b1100111: begin kind = KJalr;   imm_type = IMM_I; end
        7'b0100011: begin kind = KStore;  imm_type = IMM_S; end
        7'b1100011: begin kind = KBranch; imm_type = IMM_B; end
        7'b0110111: begin kind = KLui;    imm_type = IMM_U; end
        7'b0010111: begin kind = KAuipc;  imm_type = IMM_U; end
        7'b1101111: begin kind = KJal;    imm_type = IMM_J; end
        7'b0001111: kind = KMisc;
        default:    kind = KIllegal;
      endcase
    end
    is_illegal = (kind == KIllegal);
    // Without trapping, an illegal opcode retires exactly like a fence/NOP.
    eff_kind   = (is_illegal && !TRAP_ON_ILLEGAL) ? KMisc : kind;
  end

  always_comb begin
    state_d      = state_q;
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 1'b0;
    alu_out_we_o = 1'b0;
    pc_we_o      = 1'b0;
    pc_sel_o     = 2'd0;
    rf_we_o      = 1'b0;
    wb_sel_o     = 2'd0;
    case (state_q)
      StFetch: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) state_d = StDecode;
      end
      StDecode: state_d = (is_illegal && TRAP_ON_ILLEGAL) ? StTrap : StExecute;
      StExecute: begin
        alu_out_we_o = 1'b1;
        state_d      = StWb;
        case (eff_kind)
          KOp: ;
          KOpImm, KLui, KJalr: alu_src_b_o = 1'b1;
          KLoad, KStore: begin
            alu_src_b_o = 1'b1;
            state_d     = StMem;
          end
          KAuipc, KJal: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 1'b1;
          end
          KBranch: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 1'b1;
            pc_we_o     = 1'b1;
            pc_sel_o    = branch_taken_i ? 2'd1 : 2'd0;
            state_d     = StFetch;
          end
          default: begin
            pc_we_o = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMem: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (eff_kind == KStore);
        if (dmem_ack_i) begin
          if (eff_kind == KStore) begin
            pc_we_o = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we_o = 1'b1;
        pc_we_o = 1'b1;
        state_d = StFetch;
        if (eff_kind == KLoad) wb_sel_o = 2'd1;
        if (eff_kind == KJal || eff_kind == KJalr) begin
          wb_sel_o = 2'd2;
          pc_sel_o = 2'd2;
        end
      end
      StTrap: ;
      default: state_d = StFetch;
    endcase
    // Requests and strobes are suppressed in the very cycle reset is asserted.
    if (rst_i) begin
      imem_req_o   = 1'b0;
      dmem_req_o   = 1'b0;
      dmem_we_o    = 1'b0;
      alu_out_we_o = 1'b0;
      pc_we_o      = 1'b0;
      rf_we_o      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFetch;
      ir_q      <= RESET_IR;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch && imem_ack_i) ir_q <= imem_rdata_i;
      if (state_d == StTrap) illegal_q <= 1'b1;
    end
  end

  assign instr_o    = ir_q;
  assign imm_type_o = imm_type;
  assign illegal_o  = illegal_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instruction streams checked cycle by
// cycle against an opcode-table phase model; dut_a traps on illegal, dut_b retires as NOP.

module tb_multicycle_control;
  import riscv_pkg::*;

  localparam int KOP = 0, KOPIMM = 1, KLOAD = 2, KSTORE = 3, KBR = 4, KLUI = 5,
                 KAUIPC = 6, KJAL = 7, KJALR = 8, KMISC = 9, KILL = 10;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic imem_ack_i = 1'b0, dmem_ack_i = 1'b0, branch_taken_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  bit sel = 1'b0;
  int checks = 0, errors = 0;

  logic a_ireq, a_dreq, a_dwe, a_srca, a_srcb, a_aluwe, a_pcwe, a_rfwe, a_ill;
  logic b_ireq, b_dreq, b_dwe, b_srca, b_srcb, b_aluwe, b_pcwe, b_rfwe, b_ill;
  logic [31:0] a_instr, b_instr;
  imm_type_e a_imm, b_imm;
  logic [1:0] a_pcsel, b_pcsel, a_wbsel, b_wbsel;
  logic [2:0] a_state, b_state;

  logic o_ireq, o_dreq, o_dwe, o_srca, o_srcb, o_aluwe, o_pcwe, o_rfwe, o_ill;
  logic [31:0] o_instr;
  imm_type_e o_imm;
  logic [1:0] o_pcsel, o_wbsel;
  logic [2:0] o_state;

  always #5 clk = ~clk;

  multicycle_control #(.RESET_IR(32'h0000_0013), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .imem_req_o(a_ireq), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .dmem_req_o(a_dreq), .dmem_we_o(a_dwe),
    .dmem_ack_i(dmem_ack_i), .branch_taken_i(branch_taken_i), .instr_o(a_instr),
    .imm_type_o(a_imm), .alu_src_a_o(a_srca), .alu_src_b_o(a_srcb), .alu_out_we_o(a_aluwe),
    .pc_we_o(a_pcwe), .pc_sel_o(a_pcsel), .rf_we_o(a_rfwe), .wb_sel_o(a_wbsel),
    .illegal_o(a_ill), .state_o(a_state)
  );

  multicycle_control #(.RESET_IR(32'h0000_0013), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .imem_req_o(b_ireq), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .dmem_req_o(b_dreq), .dmem_we_o(b_dwe),
    .dmem_ack_i(dmem_ack_i), .branch_taken_i(branch_taken_i), .instr_o(b_instr),
    .imm_type_o(b_imm), .alu_src_a_o(b_srca), .alu_src_b_o(b_srcb), .alu_out_we_o(b_aluwe),
    .pc_we_o(b_pcwe), .pc_sel_o(b_pcsel), .rf_we_o(b_rfwe), .wb_sel_o(b_wbsel),
    .illegal_o(b_ill), .state_o(b_state)
  );

  assign o_ireq  = sel ? b_ireq  : a_ireq;
  assign o_dreq  = sel ? b_dreq  : a_dreq;
  assign o_dwe   = sel ? b_dwe   : a_dwe;
  assign o_srca  = sel ? b_srca  : a_srca;
  assign o_srcb  = sel ? b_srcb  : a_srcb;
  assign o_aluwe = sel ? b_aluwe : a_aluwe;
  assign o_pcwe  = sel ? b_pcwe  : a_pcwe;
  assign o_rfwe  = sel ? b_rfwe  : a_rfwe;
  assign o_ill   = sel ? b_ill   : a_ill;
  assign o_instr = sel ? b_instr : a_instr;
  assign o_imm   = sel ? b_imm   : a_imm;
  assign o_pcsel = sel ? b_pcsel : a_pcsel;
  assign o_wbsel = sel ? b_wbsel : a_wbsel;
  assign o_state = sel ? b_state : a_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (dut %s, t=%0t)", tag, obs, exp,
             sel ? "b" : "a", $time);
    end
  endtask

  // One clock: drive inputs just after the edge, then let combinational outputs settle.
  task automatic step(input logic iack, input logic [31:0] rdata, input logic dack,
                      input logic taken, input logic rst);
    @(posedge clk);
    #1;
    imem_ack_i     = iack;
    imem_rdata_i   = rdata;
    dmem_ack_i     = dack;
    branch_taken_i = taken;
    rst_i          = rst;
    #1;
  endtask

  function automatic int kind_of(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return KOP;
      7'b0010011: return KOPIMM;
      7'b0000011: return KLOAD;
      7'b0100011: return KSTORE;
      7'b1100011: return KBR;
      7'b0110111: return KLUI;
      7'b0010111: return KAUIPC;
      7'b1101111: return KJAL;
      7'b1100111: return KJALR;
      7'b0001111: return KMISC;
      default:    return KILL;
    endcase
  endfunction

  function automatic imm_type_e imm_of(input int k);
    case (k)
      KOPIMM, KLOAD, KJALR: return IMM_I;
      KSTORE:               return IMM_S;
      KBR:                  return IMM_B;
      KLUI, KAUIPC:         return IMM_U;
      KJAL:                 return IMM_J;
      default:              return IMM_NONE;
    endcase
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, " ireq"}, o_ireq, 0);
    chk({tag, " dreq"}, o_dreq, 0);
    chk({tag, " pcwe"}, o_pcwe, 0);
    chk({tag, " rfwe"}, o_rfwe, 0);
    chk({tag, " aluwe"}, o_aluwe, 0);
  endtask

  task automatic do_reset();
    step(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
    chk_quiet("rst_cycle");
    step(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
    chk_quiet("rst_hold");
    chk("rst state", o_state, 0);
    chk("rst ir", o_instr, 32'h0000_0013);
    chk("rst illegal", o_ill, 0);
    rst_i = 1'b0;
  endtask

  // Expected per-cycle behaviour follows from the instruction's phase list:
  // fetch (1+iw), decode, execute, mem (1+dw) for loads/stores, writeback unless retired early.
  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                           input bit taken);
    int k, p;
    int ph[$];
    bit last, trap, e_pcwe, e_a, e_b, is_j;
    logic [1:0] e_pcsel, e_wbsel;
    k = kind_of(ins);
    trap = (k == KILL) && !sel;
    if (k == KILL) k = KMISC;
    is_j = (k == KJAL) || (k == KJALR);
    for (int i = 0; i <= iw; i++) ph.push_back(0);
    ph.push_back(1);
    if (!trap) begin
      ph.push_back(2);
      if (k == KLOAD || k == KSTORE) for (int i = 0; i <= dw; i++) ph.push_back(3);
      if (!(k == KBR || k == KMISC || k == KSTORE)) ph.push_back(4);
    end
    for (int c = 0; c < ph.size(); c++) begin
      p = ph[c];
      last = (c == ph.size() - 1) || (ph[c+1] != p);
      step((p == 0) && last, ((p == 0) && last) ? ins : $urandom, (p == 3) && last,
           taken, 1'b0);
      e_pcwe  = (p == 2 && k == KBR) || (p == 2 && k == KMISC)
             || (p == 3 && k == KSTORE && last) || (p == 4);
      e_pcsel = (p == 2 && k == KBR && taken) ? 2'd1 : (p == 4 && is_j) ? 2'd2 : 2'd0;
      e_wbsel = (p != 4) ? 2'd0 : (k == KLOAD) ? 2'd1 : is_j ? 2'd2 : 2'd0;
      e_a = (p == 2) && (k == KAUIPC || k == KJAL || k == KBR);
      e_b = (p == 2) && !(k == KOP || k == KMISC);
      chk("state", o_state, p);
      chk("imem_req", o_ireq, p == 0);
      chk("dmem_req", o_dreq, p == 3);
      chk("dmem_we", o_dwe, (p == 3) && (k == KSTORE));
      chk("alu_out_we", o_aluwe, p == 2);
      chk("rf_we", o_rfwe, p == 4);
      chk("pc_we", o_pcwe, e_pcwe);
      if (e_pcwe) chk("pc_sel", o_pcsel, e_pcsel);
      chk("wb_sel", o_wbsel, e_wbsel);
      chk("alu_src_a", o_srca, e_a);
      chk("alu_src_b", o_srcb, e_b);
      chk("illegal", o_ill, 0);
      if (p != 0) begin
        chk("imm_type", o_imm, imm_of(kind_of(ins)));
        chk("instr", o_instr, ins);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr(input bit allow_illegal);
    logic [6:0] ops [14];
    logic [31:0] r;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b0001111,
            7'b1110011, 7'b0000001, 7'b1111111, 7'b0001011};
    r = $urandom;
    r[6:0] = ops[$urandom_range(allow_illegal ? 13 : 9, 0)];
    return r;
  endfunction

  initial begin
    sel = 1'b0;
    do_reset();

    // Directed sequence on the trapping variant.
    run_instr(32'h00500093, 0, 0, 1'b0);  // ADDI x1,x0,5
    run_instr(32'h00112223, 0, 3, 1'b0);  // SW, dmem ack after 3 waits
    run_instr(32'h00000463, 0, 0, 1'b1);  // BEQ taken
    run_instr(32'h00000463, 1, 0, 1'b0);  // BEQ not taken, one imem wait
    run_instr(32'h008000EF, 0, 0, 1'b0);  // JAL x1,+8
    run_instr(32'h0000A103, 2, 1, 1'b0);  // LW

    // ECALL traps; nothing leaves the block until reset.
    run_instr(32'h00000073, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, $urandom, $urandom_range(1, 0), $urandom_range(1, 0), 1'b0);
      chk("trap state", o_state, 5);
      chk("trap illegal", o_ill, 1);
      chk_quiet("trap");
    end
    do_reset();
    run_instr(32'h00500093, 0, 0, 1'b0);

    // Reset in the middle of a data access; a late ack must be ignored.
    step(1'b1, 32'h0000A103, 1'b0, 1'b0, 1'b0);
    step(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    chk("pre-abort state", o_state, 3);
    chk("pre-abort dreq", o_dreq, 1);
    step(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
    chk_quiet("abort_cycle");
    step(1'b0, $urandom, 1'b1, 1'b0, 1'b0);
    chk("abort state", o_state, 0);
    chk("abort dreq", o_dreq, 0);
    chk("abort ireq", o_ireq, 1);
    chk("abort ir", o_instr, 32'h0000_0013);
    chk("abort illegal", o_ill, 0);
    step(1'b0, $urandom, 1'b0, 1'b0, 1'b0);
    chk("late ack ignored", o_state, 0);

    // Random legal stream on the trapping variant.
    for (int n = 0; n < 30; n++)
      run_instr(rand_instr(1'b0), $urandom_range(2, 0), $urandom_range(3, 0),
                $urandom_range(1, 0));

    // Non-trapping variant: illegal opcodes retire as NOPs.
    sel = 1'b1;
    do_reset();
    run_instr(32'h00000073, 0, 0, 1'b0);
    for (int n = 0; n < 40; n++)
      run_instr(rand_instr(1'b1), $urandom_range(2, 0), $urandom_range(3, 0),
                $urandom_range(1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the toy RV32I core.
- Fetches an instruction over a req/ack bus and latches it into an instruction register.
- Decodes the opcode into datapath selects, including the immediate type fed to the immediate generator.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB, raising each write enable for exactly one cycle.

Parameters:
- RESET_IR, 32'h0000_0013, IR value after reset (ADDI x0,x0,0 NOP).
- TRAP_ON_ILLEGAL, 1, 1: illegal opcode enters TRAP; 0: illegal opcode is executed as a NOP (PC+4).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- imem_req_o  out  1  instruction fetch request
- imem_ack_i  in  1  fetch done, rdata valid; may assert in the same cycle as req
- imem_rdata_i  in  32  fetched instruction
- dmem_req_o  out  1  data access request
- dmem_we_o  out  1  1 = store, 0 = load; valid while dmem_req_o is high
- dmem_ack_i  in  1  data access done; may assert in the same cycle as req
- branch_taken_i  in  1  comparator result for the current branch
- instr_o  out  32  IR contents, to the immediate generator and register file
- imm_type_o  out  riscv_pkg::imm_type_e  immediate type decoded from IR
- alu_src_a_o  out  1  0 = rs1, 1 = PC
- alu_src_b_o  out  1  0 = rs2, 1 = immediate
- alu_out_we_o  out  1  capture ALU result into the datapath ALU-out register
- pc_we_o  out  1  PC write strobe
- pc_sel_o  out  2  0 = PC+4, 1 = ALU result, 2 = ALU-out register with bit0 cleared
- rf_we_o  out  1  register file write strobe
- wb_sel_o  out  2  0 = ALU-out, 1 = load data, 2 = PC+4
- illegal_o  out  1  sticky illegal-instruction flag
- state_o  out  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.
- Reset: state=FETCH, IR=RESET_IR, illegal_o=0.
- All strobes and requests (imem_req_o, dmem_req_o, pc_we_o, rf_we_o, alu_out_we_o) are 0 during reset and in the cycle reset is applied.
- Reset mid-operation: any outstanding request is dropped; a late ack is ignored outside FETCH/MEM.
- FETCH:
  - imem_req_o=1 until imem_ack_i.
  - On ack: IR<=imem_rdata_i, go to DECODE.
  - No ack: remain in FETCH with req held.
- DECODE:
  - 1 cycle; imm_type_o decoded from IR.
  - Illegal: IR[1:0]!=2'b11, or an opcode outside the list below.
    - TRAP_ON_ILLEGAL=1: go to TRAP.
    - TRAP_ON_ILLEGAL=0: treat as MISC-MEM (NOP).
  - Legal: go to EXECUTE.
- Opcode -> imm_type map:
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: IMM_I
  - STORE 0100011: IMM_S
  - BRANCH 1100011: IMM_B
  - LUI 0110111, AUIPC 0010111: IMM_U
  - JAL 1101111: IMM_J
  - OP 0110011, MISC-MEM 0001111: IMM_NONE
  - SYSTEM and all others: illegal
- imm_type_o and instr_o are combinational from IR and stay stable from DECODE until the next fetch ack.
- EXECUTE: alu_out_we_o=1 for one cycle.
  - OP: a=rs1, b=rs2; go to WB.
  - OP-IMM, LOAD, STORE: a=rs1, b=imm. OP-IMM goes to WB; LOAD and STORE go to MEM.
  - LUI: b=imm; the datapath zeroes operand a for LUI. Go to WB.
  - AUIPC, JAL: a=PC, b=imm; go to WB.
  - JALR: a=rs1, b=imm; go to WB.
  - BRANCH: a=PC, b=imm; pc_we_o=1, pc_sel_o = branch_taken_i ? 1 : 0; go to FETCH.
  - MISC-MEM: pc_we_o=1, pc_sel_o=0; go to FETCH.
- MEM:
  - dmem_req_o=1 until dmem_ack_i; dmem_we_o=1 for STORE.
  - On ack, STORE: pc_we_o=1, pc_sel_o=0, go to FETCH.
  - On ack, LOAD: go to WB.
- WB:
  - rf_we_o=1 and pc_we_o=1, one cycle each; next state FETCH.
  - wb_sel_o: LOAD=1; JAL/JALR=2; otherwise 0.
  - pc_sel_o: JAL=2 (bit0 already 0); JALR=2; otherwise 0.
- TRAP:
  - illegal_o=1, sticky.
  - All strobes and requests held at 0; leaves TRAP only on rst_i.
- Don't-care outputs: alu_src_* and wb_sel_o are don't-care when unused but must be deterministic (drive 0).
- Zero-wait-state latency: OP/OP-IMM/LUI/AUIPC/JAL/JALR 4 cycles, BRANCH 3, STORE 4, LOAD 5, MISC-MEM 3.
- Each wait-state cycle on imem or dmem adds exactly 1 cycle.
- Exactly one pc_we_o pulse per retired instruction; none in TRAP.

Test Plan:
- Reset, then imem acks ADDI x1,x0,5 (32'h00500093) same-cycle -> states 0,1,2,4,0; imm_type_o=IMM_I in DECODE; alu_src_b_o=1; rf_we_o and pc_we_o high one cycle in WB with pc_sel_o=0.
- SW (32'h00112223), dmem_ack_i delayed 3 cycles -> imm_type_o=IMM_S; dmem_req_o and dmem_we_o held 4 cycles; rf_we_o never set; pc_we_o in the ack cycle; 7 cycles total.
- BEQ (32'h00000463): branch_taken_i=1 -> pc_sel_o=1 in EXECUTE. Repeat with branch_taken_i=0 -> pc_sel_o=0. Both cases: imm_type_o=IMM_B, 3 cycles, no rf_we_o.
- JAL x1,+8 (32'h008000EF) -> imm_type_o=IMM_J; WB shows wb_sel_o=2, pc_sel_o=2. LW (32'h0000A103) -> MEM then WB with wb_sel_o=1.
- ECALL (32'h00000073), TRAP_ON_ILLEGAL=1 -> TRAP after DECODE; illegal_o=1; no requests for 20 cycles; rst_i clears it and fetch resumes. With TRAP_ON_ILLEGAL=0 -> retires as NOP with pc_sel_o=0.
- Assert rst_i during MEM with dmem_req_o high -> next cycle state=FETCH, dmem_req_o=0, IR=32'h00000013, illegal_o=0.
